// File: rtl/conv_arbiter_pkg.sv
// Shared types and widths for the fixed-to-float converter arbiter.
// Optional feature macro used by conv_arbiter: CONV_ARB_ZERO_BYPASS_EN.
package conv_arb_pkg;

  localparam int FIXED_W = 32;
  localparam int EXP_W   = 8;
  localparam int FLOAT_W = 32;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } conv_arb_state_t;

endpackage

// File: rtl/conv_arbiter_if.sv
// Requester/consumer side bundle of conv_arbiter: request bus plus response bus.
interface conv_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import conv_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*FIXED_W-1:0] req_fixed;
  logic [NUM_REQ*EXP_W-1:0]   req_exp;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [FLOAT_W-1:0]         rsp_float;
  logic                       rsp_ready;

  // Arbiter side.
  modport slave (
    input  req_valid, req_fixed, req_exp, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_float
  );

  // Producer/consumer side.
  modport master (
    output req_valid, req_fixed, req_exp, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_float
  );

endinterface

// File: rtl/conv_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, priority pointer advances past
// the winner only when the grant is taken (advance).
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  int               pos;

  // Scan starting at the pointer, wrapping once around the requesters.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_reg) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        win_idx    = IDX_W'(pos);
      end
    end
  end

  assign ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/conv_arbiter.sv
// Shares one fixed-to-float converter between NUM_REQ requesters (round robin).
// Define CONV_ARB_ZERO_BYPASS_EN to answer zero operands without the converter.
module conv_arbiter
  import conv_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CONV_CYCLES = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_arbiter_if.slave      bus,
  output logic [FIXED_W-1:0] conv_fixed,
  output logic [EXP_W-1:0]   conv_exp,
  output logic               conv_load,
  input  logic [FLOAT_W-1:0] conv_float
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  conv_arb_state_t state_reg;
  conv_arb_state_t state_next;

  logic [CNT_W-1:0]   cnt_reg;
  logic [FIXED_W-1:0] conv_fixed_reg;
  logic [EXP_W-1:0]   conv_exp_reg;
  logic [IDX_W-1:0]   rsp_id_reg;
  logic [FLOAT_W-1:0] rsp_float_reg;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic [FIXED_W-1:0] win_fixed;
  logic [EXP_W-1:0]   win_exp;
  logic               req_hs;
  logic               ready_en;
  logic               rsp_valid_int;
  logic               zero_bypass;

  logic [FIXED_W-1:0] fixed_arr [NUM_REQ];
  logic [EXP_W-1:0]   exp_arr   [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign fixed_arr[gi] = bus.req_fixed[gi*FIXED_W +: FIXED_W];
      assign exp_arr[gi]   = bus.req_exp[gi*EXP_W +: EXP_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .advance (req_hs),
    .grant   (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        win_idx = IDX_W'(k);
      end
    end
  end

  assign win_fixed = fixed_arr[win_idx];
  assign win_exp   = exp_arr[win_idx];

  // Grants are only visible in IDLE and never while reset is held.
  assign req_hs = rst_n && (state_reg == IDLE) && (|grant);

`ifdef CONV_ARB_ZERO_BYPASS_EN
  assign zero_bypass = (win_fixed == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    conv_load     = 1'b0;
    rsp_valid_int = 1'b0;
    ready_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_en = rst_n;
        if (req_hs) begin
          state_next = zero_bypass ? RESP : LOAD;
        end
      end
      LOAD: begin
        conv_load  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid_int = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands stay in the converter registers until the next converter grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      conv_fixed_reg <= '0;
      conv_exp_reg   <= '0;
      rsp_id_reg     <= '0;
      rsp_float_reg  <= '0;
    end else begin
      if (state_reg == LOAD) begin
        cnt_reg <= CNT_W'(CONV_CYCLES - 1);
      end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (req_hs) begin
        rsp_id_reg <= win_idx;
        if (zero_bypass) begin
          rsp_float_reg <= FLOAT_ZERO;
        end else begin
          conv_fixed_reg <= win_fixed;
          conv_exp_reg   <= win_exp;
        end
      end
      if ((state_reg == WAIT) && (cnt_reg == '0)) begin
        rsp_float_reg <= conv_float;
      end
    end
  end

  assign bus.req_ready = ready_en ? grant : '0;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_float = rsp_float_reg;
  assign conv_fixed    = conv_fixed_reg;
  assign conv_exp      = conv_exp_reg;

endmodule

// File: tb/tb_conv_arbiter.sv
// Self-checking bench for conv_arbiter with a behavioural fixed-to-float converter.
module tb_conv_arbiter;

  localparam int N    = 4;
  localparam int CONV = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] conv_fixed;
  logic [7:0]  conv_exp;
  logic        conv_load;
  logic [31:0] conv_float;

  conv_arbiter_if #(.NUM_REQ(N)) bus ();

  conv_arbiter #(
    .NUM_REQ     (N),
    .CONV_CYCLES (CONV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .conv_fixed (conv_fixed),
    .conv_exp   (conv_exp),
    .conv_load  (conv_load),
    .conv_float (conv_float)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // value = fixed * 2^exp, rounded to nearest even single precision.
  function automatic logic [31:0] to_float(input logic [31:0] fx, input logic [7:0] ex);
    logic        sgn;
    logic [31:0] mag, man, rem, half;
    int          p, s, be;
    if (fx == 32'd0) return 32'd0;
    sgn = fx[31];
    mag = sgn ? (~fx + 32'd1) : fx;
    p = 0;
    for (int b = 0; b < 32; b++) if (mag[b]) p = b;
    if (p <= 23) begin
      man = mag << (23 - p);
    end else begin
      s    = p - 23;
      man  = mag >> s;
      rem  = mag & ((32'd1 << s) - 32'd1);
      half = 32'd1 << (s - 1);
      if (rem > half || (rem == half && man[0])) man = man + 32'd1;
      if (man[24]) begin
        man = man >> 1;
        p   = p + 1;
      end
    end
    be = p + int'($signed(ex)) + 127;
    return {sgn, be[7:0], man[22:0]};
  endfunction

  // Converter model: result valid CONV cycles after the load pulse ends.
  logic [31:0] cv_res;
  int          cv_cnt;
  logic        cv_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_busy <= 1'b0;
      cv_cnt  <= 0;
    end else if (conv_load) begin
      cv_res  <= to_float(conv_fixed, conv_exp);
      cv_cnt  <= CONV - 1;
      cv_busy <= 1'b1;
    end else if (cv_cnt > 0) begin
      cv_cnt <= cv_cnt - 1;
    end
  end
  assign conv_float = (cv_busy && cv_cnt == 0) ? cv_res : 32'hdead_beef;

  // A load pulse must always directly follow a request handshake.
  logic hs_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && conv_load) check_eq("load_after_hs", {31'd0, hs_prev}, 32'd1);
    hs_prev <= rst_n && (|(bus.req_valid & bus.req_ready));
  end

  // Requester model.
  bit          vld [N];
  logic [31:0] fx  [N];
  logic [7:0]  ex  [N];
  int          ptr_m;
  logic [31:0] last_fx;
  logic [7:0]  last_ex;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = vld[i];
      bus.req_fixed[32*i +: 32] = fx[i];
      bus.req_exp[8*i +: 8]     = ex[i];
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_ready"}, {28'd0, bus.req_ready}, 32'd0);
    check_eq({tag, "_conv_load"}, {31'd0, conv_load}, 32'd0);
    check_eq({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check_eq({tag, "_rsp_id"}, {30'd0, bus.rsp_id}, 32'd0);
    check_eq({tag, "_rsp_float"}, bus.rsp_float, 32'd0);
    check_eq({tag, "_conv_fixed"}, conv_fixed, 32'd0);
    check_eq({tag, "_conv_exp"}, {24'd0, conv_exp}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n   = 1'b1;
    ptr_m   = 0;
    last_fx = 32'd0;
    last_ex = 8'd0;
  endtask

  // Serve the next request the model expects; optionally stall or abort by reset.
  task automatic serve(input int bp, input bit hold, input int abort_at);
    int          exp_id, k, loads, rr_bad, stable_bad, c;
    bit          seen, byp;
    logic [31:0] exp_f, sv_f;
    logic [1:0]  sv_id;
    exp_id = -1;
    for (int j = 0; j < N; j++) begin
      c = (ptr_m + j) % N;
      if (exp_id < 0 && vld[c]) exp_id = c;
    end
    if (exp_id < 0) return;
    #1;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (|(bus.req_valid & bus.req_ready)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("hs_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    check_eq("grant", {28'd0, bus.req_ready}, 32'd1 << exp_id);
`ifdef CONV_ARB_ZERO_BYPASS_EN
    byp = (fx[exp_id] == 32'd0);
`else
    byp = 1'b0;
`endif
    exp_f = byp ? 32'd0 : to_float(fx[exp_id], ex[exp_id]);
    if (!byp) begin
      last_fx = fx[exp_id];
      last_ex = ex[exp_id];
    end
    ptr_m = (exp_id + 1) % N;
    @(posedge clk);
    #1;
    if (!hold) begin
      vld[exp_id] = 1'b0;
      apply();
    end
    loads  = 0;
    rr_bad = 0;
    k      = 0;
    while (k < CONV + 20) begin
      @(negedge clk);
      k++;
      if (abort_at > 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        rst_n   = 1'b1;
        ptr_m   = 0;
        last_fx = 32'd0;
        last_ex = 8'd0;
        $display("txn id=%0d aborted by reset at cycle %0d", exp_id, k);
        return;
      end
      if (conv_load) begin
        loads++;
        check_eq("load_cycle", k, 32'd1);
        check_eq("conv_fixed_load", conv_fixed, last_fx);
        check_eq("conv_exp_load", {24'd0, conv_exp}, {24'd0, last_ex});
      end
      if (|bus.req_ready) rr_bad++;
      if (bus.rsp_valid) break;
    end
    check_eq("rsp_latency", k, byp ? 32'd1 : 32'(CONV + 2));
    check_eq("rsp_id", {30'd0, bus.rsp_id}, 32'(exp_id));
    check_eq("rsp_float", bus.rsp_float, exp_f);
    check_eq("load_count", loads, byp ? 32'd0 : 32'd1);
    check_eq("ready_busy", rr_bad, 32'd0);
    check_eq("conv_fixed_hold", conv_fixed, last_fx);
    sv_f       = bus.rsp_float;
    sv_id      = bus.rsp_id;
    stable_bad = 0;
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_float !== sv_f || bus.rsp_id !== sv_id ||
          conv_load || (|bus.req_ready)) stable_bad++;
    end
    if (bp > 0) check_eq("bp_stable", stable_bad, 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check_eq("rsp_accepted", {31'd0, bus.rsp_valid}, 32'd0);
    $display("txn id=%0d fixed=%h exp=%0d float=%h latency=%0d stall=%0d",
             exp_id, fx[exp_id], $signed(ex[exp_id]), sv_f, k, bp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      fx[i]  = 32'd0;
      ex[i]  = 8'd0;
    end
    apply();
    do_reset();

    // Single request 1.0.
    vld[0] = 1'b1; fx[0] = 32'd1; ex[0] = 8'd0; apply();
    serve(0, 1'b0, 0);

    // Reset in the middle of WAIT; requester 0 must win first afterwards.
    vld[2] = 1'b1; fx[2] = 32'd5; ex[2] = 8'd3; apply();
    serve(0, 1'b0, 10);
    vld[0] = 1'b1; fx[0] = 32'd7; ex[0] = 8'd0;
    vld[2] = 1'b1; fx[2] = 32'd9; ex[2] = 8'd2; apply();
    serve(0, 1'b0, 0);
    serve(0, 1'b0, 0);

    // All four at once, requests held through reset; one response stalled 10 cycles.
    vld[0] = 1'b1; fx[0] = 32'd1;          ex[0] = 8'd0;
    vld[1] = 1'b1; fx[1] = 32'd1;          ex[1] = 8'd1;
    vld[2] = 1'b1; fx[2] = 32'd13;         ex[2] = 8'd255;
    vld[3] = 1'b1; fx[3] = 32'hffff_ffff;  ex[3] = 8'd0;
    apply();
    do_reset();
    serve(0, 1'b0, 0);
    serve(10, 1'b0, 0);
    serve(0, 1'b0, 0);
    serve(0, 1'b0, 0);

    // Requesters 1 and 3 held valid continuously.
    vld[1] = 1'b1; fx[1] = 32'd100; ex[1] = 8'd2;
    vld[3] = 1'b1; fx[3] = 32'hffff_fc00; ex[3] = 8'd250;
    apply();
    for (int r = 0; r < 4; r++) serve(0, 1'b1, 0);
    vld[1] = 1'b0; vld[3] = 1'b0; apply();

    // Zero operand: bypassed or full latency depending on the build.
    vld[2] = 1'b1; fx[2] = 32'd0; ex[2] = 8'd5; apply();
    serve(0, 1'b0, 0);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && ($urandom % 2 == 0)) begin
          vld[i] = 1'b1;
          fx[i]  = ($urandom % 4 == 0) ? 32'd0 : $urandom;
          ex[i]  = 8'(int'($urandom_range(0, 120)) - 60);
        end else if (vld[i] && ($urandom % 6 == 0)) begin
          vld[i] = 1'b0;
        end
      end
      if (!(vld[0] || vld[1] || vld[2] || vld[3])) begin
        vld[it % N] = 1'b1;
        fx[it % N]  = $urandom;
        ex[it % N]  = 8'(int'($urandom_range(0, 120)) - 60);
      end
      apply();
      serve(($urandom % 4 == 0) ? int'($urandom_range(1, 6)) : 0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
